// File: rtl/plab3_mem_l2_writeback_buffer.sv
// rtl/plab3_mem_l2_writeback_buffer.sv - write-back buffer between the L2 cache and main memory
//
// Absorbs line-sized eviction writes from the L2, acknowledges them locally and
// drains them to memory in the background. Reads of a buffered line are served
// from the youngest matching entry. Read misses and other request types are
// latched and forwarded to memory, with their responses passed through unchanged.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   memreq_val/rdy/msg                 request from L2  {type,opaque,addr,len,data}
//   memresp_val/rdy/msg                response to L2   {type,opaque,len,data}
//   mem_memreq_val/rdy/msg             request to memory
//   mem_memresp_val/rdy/msg            response from memory
//   occupancy                          number of valid buffered writes
//
// Optional: define PLAB3_MEM_WBB_COALESCE_EN to merge a WRITE into an existing
// buffered entry for the same line instead of allocating a new one.

module plab3_mem_l2_writeback_buffer #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 128,
  parameter int p_num_entries  = 4,
  localparam int c_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + 4 + p_data_nbits,
  localparam int c_resp_nbits = 3 + p_opaque_nbits + 4 + p_data_nbits,
  localparam int c_line_nbits = p_addr_nbits - 4,
  localparam int c_ptr_nbits  = $clog2(p_num_entries),
  localparam int c_occ_nbits  = $clog2(p_num_entries + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memreq_val,
  output logic                    memreq_rdy,
  input  logic [c_req_nbits-1:0]  memreq_msg,
  output logic                    memresp_val,
  input  logic                    memresp_rdy,
  output logic [c_resp_nbits-1:0] memresp_msg,
  output logic                    mem_memreq_val,
  input  logic                    mem_memreq_rdy,
  output logic [c_req_nbits-1:0]  mem_memreq_msg,
  input  logic                    mem_memresp_val,
  output logic                    mem_memresp_rdy,
  input  logic [c_resp_nbits-1:0] mem_memresp_msg,
  output logic [c_occ_nbits-1:0]  occupancy
);

  localparam logic [2:0] c_read  = 3'd0;
  localparam logic [2:0] c_write = 3'd1;

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT} state_t;

  state_t                    state, state_next;
  logic [c_ptr_nbits-1:0]    head, tail;
  logic [c_occ_nbits-1:0]    count;
  logic                      pending;
  logic                      loc_val;
  logic [c_resp_nbits-1:0]   loc_msg;
  logic                      lreq_val;
  logic [c_req_nbits-1:0]    lreq_msg;
  logic [c_line_nbits-1:0]   line_q [p_num_entries];
  logic [p_data_nbits-1:0]   data_q [p_num_entries];

  // Request field views
  logic [2:0]                req_type;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic [c_line_nbits-1:0]   req_line;
  logic [p_data_nbits-1:0]   req_data;

  assign req_type   = memreq_msg[c_req_nbits-1 -: 3];
  assign req_opaque = memreq_msg[p_data_nbits+4+p_addr_nbits +: p_opaque_nbits];
  assign req_line   = memreq_msg[p_data_nbits+8 +: c_line_nbits];
  assign req_data   = memreq_msg[p_data_nbits-1:0];

  // Youngest-first search: scanning oldest to youngest lets the youngest match win.
  logic                   hit;
  logic [c_ptr_nbits-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = p_num_entries; k >= 1; k--) begin
      if (k <= int'(count) && line_q[tail - c_ptr_nbits'(k)] == req_line) begin
        hit     = 1'b1;
        hit_idx = tail - c_ptr_nbits'(k);
      end
    end
  end

  logic full, is_write, is_read, wr_coal, accept;
  logic enq, deq, acc_rd_miss, acc_other, rd_elig;

  assign full     = (count == c_occ_nbits'(p_num_entries));
  assign is_write = (req_type == c_write);
  assign is_read  = (req_type == c_read);

`ifdef PLAB3_MEM_WBB_COALESCE_EN
  // The head cannot be modified once its drain request may already be on the bus.
  assign wr_coal    = is_write && hit &&
                      ((hit_idx != head) || !(state == S_WR_REQ || state == S_WR_WAIT));
  assign memreq_rdy = !pending && (!full || wr_coal);
`else
  assign wr_coal    = 1'b0;
  assign memreq_rdy = !pending && !full;
`endif

  assign accept      = memreq_val && memreq_rdy;
  assign enq         = accept && is_write && !wr_coal;
  assign deq         = (state == S_WR_WAIT) && mem_memresp_val;
  assign acc_rd_miss = accept && is_read && !hit;
  assign acc_other   = accept && !is_read && !is_write;

  // A read miss may go out immediately; other types must wait for an empty buffer.
  assign rd_elig = (lreq_val && (lreq_msg[c_req_nbits-1 -: 3] == c_read || count == '0))
                 || acc_rd_miss || (acc_other && count == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (rd_elig)             state_next = S_RD_REQ;
                 else if (count != '0)    state_next = S_WR_REQ;
      S_RD_REQ:  if (mem_memreq_rdy)      state_next = S_RD_WAIT;
      S_RD_WAIT: if (mem_memresp_val && memresp_rdy) state_next = S_IDLE;
      S_WR_REQ:  if (mem_memreq_rdy)      state_next = S_WR_WAIT;
      S_WR_WAIT: if (mem_memresp_val)     state_next = S_IDLE;
      default:                            state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_memreq_val  = 1'b0;
    mem_memreq_msg  = '0;
    mem_memresp_rdy = 1'b0;
    case (state)
      S_RD_REQ: begin
        mem_memreq_val = 1'b1;
        mem_memreq_msg = lreq_msg;
      end
      S_RD_WAIT: mem_memresp_rdy = memresp_rdy;
      S_WR_REQ: begin
        mem_memreq_val = 1'b1;
        mem_memreq_msg = {c_write, {p_opaque_nbits{1'b0}}, line_q[head], 4'b0000,
                          4'b0000, data_q[head]};
      end
      S_WR_WAIT: mem_memresp_rdy = 1'b1;
      default: ;
    endcase
    // Only one L2 transaction is ever outstanding, so local and passthrough never collide.
    memresp_val = loc_val || ((state == S_RD_WAIT) && mem_memresp_val);
    memresp_msg = loc_val ? loc_msg : mem_memresp_msg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pending  <= 1'b0;
      loc_val  <= 1'b0;
      loc_msg  <= '0;
      lreq_val <= 1'b0;
      lreq_msg <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (accept)                          pending <= 1'b1;
      else if (memresp_val && memresp_rdy) pending <= 1'b0;

      if (accept && (is_write || (is_read && hit))) begin
        loc_val <= 1'b1;
        loc_msg <= is_write ? {c_write, req_opaque, 4'b0000, {p_data_nbits{1'b0}}}
                            : {c_read, req_opaque, 4'b0000, data_q[hit_idx]};
      end else if (loc_val && memresp_rdy) begin
        loc_val <= 1'b0;
      end

      if (acc_rd_miss || acc_other) begin
        lreq_val <= 1'b1;
        lreq_msg <= memreq_msg;
      end else if (state == S_RD_REQ && mem_memreq_rdy) begin
        lreq_val <= 1'b0;
      end
    end
  end

  // Entry storage; validity is tracked by head/count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      if (wr_coal) begin
        data_q[hit_idx] <= req_data;
      end else begin
        line_q[tail] <= req_line;
        data_q[tail] <= req_data;
      end
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_plab3_mem_l2_writeback_buffer.sv
// tb/tb_plab3_mem_l2_writeback_buffer.sv - scoreboard bench for plab3_mem_l2_writeback_buffer

module tb_plab3_mem_l2_writeback_buffer;

  localparam logic [2:0] RD = 3'd0, WR = 3'd1, INIT = 3'd2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         memreq_val = 1'b0, memreq_rdy;
  logic [174:0] memreq_msg = '0;
  logic         memresp_val, memresp_rdy;
  logic [142:0] memresp_msg;
  logic         mem_memreq_val, mem_memreq_rdy;
  logic [174:0] mem_memreq_msg;
  logic         mem_memresp_val, mem_memresp_rdy;
  logic [142:0] mem_memresp_msg;
  logic [2:0]   occupancy;

  plab3_mem_l2_writeback_buffer dut (
    .clk(clk), .reset(reset),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .mem_memreq_val(mem_memreq_val), .mem_memreq_rdy(mem_memreq_rdy), .mem_memreq_msg(mem_memreq_msg),
    .mem_memresp_val(mem_memresp_val), .mem_memresp_rdy(mem_memresp_rdy), .mem_memresp_msg(mem_memresp_msg),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [142:0] msg; bit chk_lat; int acc_cyc; } exp_t;

  int errors = 0, checks = 0;
  bit rdy_rand = 0, mem_rand = 0, mem_stall = 0, resp_hold = 0;

  exp_t         exp_q[$];
  logic [142:0] mresp_q[$];
  logic [174:0] mlog[$];
  logic [155:0] drain_q[$];
  logic [127:0] mem_arr[logic [27:0]];
  logic [127:0] shadow[logic [27:0]];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=no-event required=event", name);
  endtask

  function automatic logic [127:0] init_val(input logic [27:0] line);
    return {4{{4'h0, line} ^ 32'hA5C30000}};
  endfunction

  function automatic logic [127:0] sh_rd(input logic [27:0] line);
    return shadow.exists(line) ? shadow[line] : init_val(line);
  endfunction

  function automatic logic [127:0] mem_rd(input logic [27:0] line);
    return mem_arr.exists(line) ? mem_arr[line] : init_val(line);
  endfunction

  function automatic int rd_count();
    int n = 0;
    foreach (mlog[i]) if (mlog[i][174:172] == RD) n++;
    return n;
  endfunction

  // L2-side monitor: pops the expected response whenever one is handed over.
  initial begin
    exp_t e;
    memresp_rdy = 1'b0;
    forever begin
      @(negedge clk);
      memresp_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      #2;
      if (!reset && memresp_val && memresp_rdy) begin
        if (exp_q.size() == 0) fail_now("resp_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("resp_msg", {49'h0, memresp_msg}, {49'h0, e.msg});
          if (e.chk_lat) chk("resp_latency", cyc, e.acc_cyc + 1);
        end
      end
    end
  end

  // Main memory model: one outstanding request, optional random stalls.
  initial begin
    logic [174:0] m;
    logic [27:0]  line;
    mem_memreq_rdy  = 1'b0;
    mem_memresp_val = 1'b0;
    mem_memresp_msg = '0;
    forever begin
      @(negedge clk);
      mem_memreq_rdy  = mem_stall ? 1'b0 : (mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      mem_memresp_val = (mresp_q.size() > 0) && !resp_hold && (!mem_rand || $urandom_range(0, 2) != 0);
      mem_memresp_msg = (mresp_q.size() > 0) ? mresp_q[0] : '0;
      #2;
      if (!reset) begin
        if (mem_memresp_val && mem_memresp_rdy) void'(mresp_q.pop_front());
        if (mem_memreq_val && mem_memreq_rdy) begin
          m = mem_memreq_msg;
          line = m[163:136];
          mlog.push_back(m);
          case (m[174:172])
            WR: begin
              chk("drain_fmt", {m[171:164], m[135:128]}, 16'h0);
`ifndef PLAB3_MEM_WBB_COALESCE_EN
              if (drain_q.size() == 0) fail_now("drain_unexpected");
              else chk("drain_line_data", {line, m[127:0]}, drain_q.pop_front());
`endif
              mem_arr[line] = m[127:0];
              mresp_q.push_back({WR, m[171:164], 4'h0, 128'h0});
            end
            RD: mresp_q.push_back({RD, m[171:164], 4'h0, mem_rd(line)});
            default: begin
              mem_arr[line] = m[127:0];
              mresp_q.push_back({m[174:172], m[171:164], 4'h0, 128'h0});
            end
          endcase
        end
      end
    end
  end

  task automatic send(input logic [2:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                      input logic [127:0] data, input bit lat);
    int n = 0;
    bit done = 0;
    exp_t e;
    logic [27:0] line = addr[31:4];
    while (!done) begin
      @(negedge clk);
      memreq_val = 1'b1;
      memreq_msg = {typ, opq, addr, 4'h0, data};
      #2;
      if (memreq_rdy) begin
        done = 1;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        case (typ)
          WR: begin
            e.msg = {WR, opq, 4'h0, 128'h0};
            shadow[line] = data;
`ifndef PLAB3_MEM_WBB_COALESCE_EN
            drain_q.push_back({line, data});
`endif
          end
          RD: e.msg = {RD, opq, 4'h0, sh_rd(line)};
          default: begin
            e.msg = {typ, opq, 4'h0, 128'h0};
            shadow[line] = data;
          end
        endcase
        exp_q.push_back(e);
      end else if (++n >= 3000) begin
        fail_now("send_timeout");
        done = 1;
      end
    end
    @(posedge clk);
    #1 memreq_val = 1'b0;
  endtask

  task automatic sample(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic wait_quiet();
    int n = 0;
    do begin
      sample(1);
      n++;
    end while (!(exp_q.size() == 0 && occupancy == 0 && mresp_q.size() == 0 && !mem_memreq_val)
               && n < 6000);
    if (n >= 6000) fail_now("quiet_timeout");
  endtask

  task automatic chk_log(input string name, input int idx, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [127:0] data);
    if (idx >= mlog.size()) fail_now(name);
    else chk(name, {mlog[idx][174:172], mlog[idx][163:132], mlog[idx][127:0]}, {typ, addr, data});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [127:0] da, db, dc, dd, dx;
    logic [2:0] typ;
    logic [31:0] addr;
    int r;

    #1 reset = 1'b1;
    sample(3);
    chk("rst_occ", occupancy, 0);
    chk("rst_memresp_val", memresp_val, 0);
    chk("rst_mem_memreq_val", mem_memreq_val, 0);
    chk("rst_mem_memresp_rdy", mem_memresp_rdy, 0);
    @(negedge clk) reset = 1'b0;
    sample(1);
    chk("idle_memreq_rdy", memreq_rdy, 1);

    // Single write: local ack, buffered, then drained once memory is ready.
    da = {4{32'h0A0A0A0A}};
    mem_stall = 1;
    send(WR, 8'h11, 32'h1000, da, 1);
    sample(1);
    chk("t1_occ", occupancy, 1);
    n0 = mlog.size();
    mem_stall = 0;
    wait_quiet();
    chk("t1_drain_cnt", mlog.size(), n0 + 1);
    chk_log("t1_drain", n0, WR, 32'h1000, da);
    chk("t1_occ_end", occupancy, 0);

    // Read forwarded from a buffered write.
    db = {4{32'hB0B0B0B0}};
    mem_stall = 1;
    send(WR, 8'h21, 32'h2000, db, 1);
    n0 = rd_count();
    send(RD, 8'h22, 32'h2008, '0, 1);
    mem_stall = 0;
    wait_quiet();
    chk("t2_no_mem_read", rd_count(), n0);

    // Full buffer stalls a read; once a slot frees, the read beats the remaining drains.
    mem_stall = 1;
    for (int i = 1; i <= 4; i++) send(WR, 8'h30 + 8'(i), 32'h3000 + 32'(i) * 32'h100, {4{32'(i)}}, 1);
    sample(3);
    chk("t3_occ_full", occupancy, 4);
    chk("t3_full_rdy", memreq_rdy, 0);
    n0 = mlog.size();
    fork
      send(RD, 8'h35, 32'h3000, '0, 0);
    join_none
    sample(5);
    chk("t3_read_held", exp_q.size(), 0);
    mem_stall = 0;
    wait_quiet();
    chk_log("t3_order0", n0,     WR, 32'h3100, {4{32'd1}});
    chk_log("t3_order1", n0 + 1, RD, 32'h3000, '0);
    chk_log("t3_order2", n0 + 2, WR, 32'h3200, {4{32'd2}});
    chk_log("t3_order3", n0 + 3, WR, 32'h3300, {4{32'd3}});
    chk_log("t3_order4", n0 + 4, WR, 32'h3400, {4{32'd4}});

    // Same-line writes behind a draining head.
    dx = {4{32'h55555555}};
    dc = {4{32'hCCCCCCCC}};
    dd = {4{32'hDDDDDDDD}};
    mem_stall = 1;
    send(WR, 8'h40, 32'h5000, dx, 1);
    send(WR, 8'h41, 32'h4000, dc, 1);
    send(WR, 8'h42, 32'h4000, dd, 1);
    send(RD, 8'h43, 32'h4000, '0, 1);
    sample(1);
    n0 = mlog.size();
`ifdef PLAB3_MEM_WBB_COALESCE_EN
    chk("t4_occ", occupancy, 2);
`else
    chk("t4_occ", occupancy, 3);
`endif
    mem_stall = 0;
    wait_quiet();
    chk_log("t4_drain0", n0, WR, 32'h5000, dx);
`ifdef PLAB3_MEM_WBB_COALESCE_EN
    chk_log("t4_drain1", n0 + 1, WR, 32'h4000, dd);
    chk("t4_drain_cnt", mlog.size(), n0 + 2);
`else
    chk_log("t4_drain1", n0 + 1, WR, 32'h4000, dc);
    chk_log("t4_drain2", n0 + 2, WR, 32'h4000, dd);
    chk("t4_drain_cnt", mlog.size(), n0 + 3);
`endif

    // INIT waits for the buffer to empty.
    mem_stall = 1;
    send(WR, 8'h50, 32'h7000, {4{32'hE}}, 1);
    send(WR, 8'h51, 32'h7100, {4{32'hF}}, 1);
    send(INIT, 8'h55, 32'h7200, {4{32'h1234}}, 0);
    n0 = mlog.size();
    mem_stall = 0;
    wait_quiet();
    chk_log("t5_order0", n0,     WR,   32'h7000, {4{32'hE}});
    chk_log("t5_order1", n0 + 1, WR,   32'h7100, {4{32'hF}});
    chk_log("t5_order2", n0 + 2, INIT, 32'h7200, {4{32'h1234}});

    // Reset while a drain waits for its memory response.
    mem_stall = 1;
    for (int i = 0; i < 3; i++) send(WR, 8'h60, 32'h6000 + 32'(i) * 32'h10, {4{32'h600 + 32'(i)}}, 1);
    sample(2);
    chk("t6_occ", occupancy, 3);
    n0 = mlog.size();
    resp_hold = 1;
    mem_stall = 0;
    r = 0;
    while (mlog.size() == n0 && r < 100) begin sample(1); r++; end
    if (mlog.size() == n0) fail_now("t6_drain_start");
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mresp_q.delete();
    drain_q.delete();
    shadow.delete();
    foreach (mem_arr[k]) shadow[k] = mem_arr[k];
    #3;
    chk("t6_occ_rst", occupancy, 0);
    chk("t6_vals_rst", {memresp_val, mem_memreq_val, mem_memresp_rdy}, 0);
    @(negedge clk);
    reset = 1'b0;
    resp_hold = 0;
    n0 = rd_count();
    send(RD, 8'h66, 32'h6010, '0, 0);
    send(RD, 8'h67, 32'h6000, '0, 0);
    wait_quiet();
    chk("t6_read_mem", rd_count(), n0 + 2);

    // Randomized traffic over a small set of lines.
    rdy_rand = 1;
    mem_rand = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      typ = (r < 45) ? WR : (r < 93) ? RD : INIT;
      addr = 32'h8000 + 32'($urandom_range(0, 5)) * 32'h10 + 32'($urandom_range(0, 15));
      send(typ, 8'($urandom), addr, {$urandom, $urandom, $urandom, $urandom}, 0);
      if ($urandom_range(0, 3) == 0) sample($urandom_range(1, 4));
    end
    wait_quiet();
    foreach (shadow[k]) chk("final_mem", mem_rd(k), shadow[k]);
    chk("final_drain_q", drain_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
